// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Latches the instruction leaving
// memory, shapes load data and drives the register-file write port.
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        wb_allowin,
  input  logic [31:0] mem_pc,
  input  logic [2:0]  mem_load_op,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rt_value,
  input  logic [4:0]  mem_dest,
  input  logic        mem_rf_we,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_fwd_valid,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic [31:0] inst_retired
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_LWL  = 3'd6;
  localparam logic [2:0] OP_LWR  = 3'd7;

  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [2:0]  wb_load_op;
  logic [1:0]  wb_addr_lo;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_rt_value;
  logic [4:0]  wb_dest;
  logic        wb_rf_we;

  logic        first;
  logic [31:0] hold_word;

  logic        capture;
  logic        commit;
  logic        writes_reg;

  logic [31:0] src_word;
  logic [4:0]  lo_sh;
  logic [4:0]  hi_sh;
  logic [31:0] shr_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_keep;
  logic [31:0] load_data;

  assign wb_allowin = !wb_valid || !wb_stall;
  assign capture    = mem_valid && wb_allowin;
  assign commit     = wb_valid && !wb_stall;
  assign writes_reg = wb_rf_we && (wb_dest != 5'd0);

  // pipeline register: load on allow-in, drop to a bubble when memory is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_pc         <= 32'd0;
      wb_load_op    <= 3'd0;
      wb_addr_lo    <= 2'd0;
      wb_alu_result <= 32'd0;
      wb_rt_value   <= 32'd0;
      wb_dest       <= 5'd0;
      wb_rf_we      <= 1'b0;
    end else if (wb_allowin) begin
      wb_valid <= mem_valid;
      if (mem_valid) begin
        wb_pc         <= mem_pc;
        wb_load_op    <= mem_load_op;
        wb_addr_lo    <= mem_addr_lo;
        wb_alu_result <= mem_alu_result;
        wb_rt_value   <= mem_rt_value;
        wb_dest       <= mem_dest;
        wb_rf_we      <= mem_rf_we;
      end
    end
  end

  // RAM word is only live in the first WB cycle; keep it if we stall there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first     <= 1'b0;
      hold_word <= 32'd0;
    end else begin
      first <= capture;
      if (first && wb_stall) begin
        hold_word <= data_sram_rdata;
      end
    end
  end

  assign src_word = first ? data_sram_rdata : hold_word;

  assign lo_sh    = {wb_addr_lo, 3'b000};
  assign hi_sh    = {~wb_addr_lo, 3'b000};
  assign shr_word = src_word >> lo_sh;
  assign byte_sel = shr_word[7:0];
  assign half_sel = wb_addr_lo[1] ? src_word[31:16]
                                  : src_word[15:0];
  assign lwl_mask = (32'd1 << hi_sh) - 32'd1;
  assign lwr_keep = ~(32'hFFFF_FFFF >> lo_sh);

  // load extraction and unaligned merge
  always_comb begin
    load_data = wb_alu_result;
    unique case (wb_load_op)
      OP_NONE: load_data = wb_alu_result;
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      OP_LW:   load_data = src_word;
      OP_LWL:  load_data = (src_word << hi_sh)
                         | (wb_rt_value & lwl_mask);
      OP_LWR:  load_data = shr_word
                         | (wb_rt_value & lwr_keep);
    endcase
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_retired <= 32'd0;
    end else if (commit) begin
      inst_retired <= inst_retired + 32'd1;
    end
  end

  assign rf_we        = commit && writes_reg;
  assign rf_waddr     = wb_dest;
  assign rf_wdata     = load_data;
  assign wb_fwd_valid = wb_valid && writes_reg;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: vector table, directed corner sequences and a
// randomized run against a byte-level reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rt_value;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [31:0] data_sram_rdata;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_fwd_valid;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] inst_retired;

  writeback_stage dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_pc(mem_pc), .mem_load_op(mem_load_op),
    .mem_addr_lo(mem_addr_lo),
    .mem_alu_result(mem_alu_result),
    .mem_rt_value(mem_rt_value), .mem_dest(mem_dest),
    .mem_rf_we(mem_rf_we),
    .data_sram_rdata(data_sram_rdata),
    .wb_stall(wb_stall), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_fwd_valid(wb_fwd_valid),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .inst_retired(inst_retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] rt;
    logic [31:0] alu;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic        we;
  } instr_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_valid       = 1'b0;
    mem_pc          = 32'd0;
    mem_load_op     = 3'd0;
    mem_addr_lo     = 2'd0;
    mem_alu_result  = 32'd0;
    mem_rt_value    = 32'd0;
    mem_dest        = 5'd0;
    mem_rf_we       = 1'b0;
    wb_stall        = 1'b0;
    data_sram_rdata = 32'd0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [2:0] op,
                      input logic [1:0] lo, input logic [31:0] alu,
                      input logic [31:0] rt, input logic [4:0] dest,
                      input logic we);
    mem_valid      = 1'b1;
    mem_pc         = pc;
    mem_load_op    = op;
    mem_addr_lo    = lo;
    mem_alu_result = alu;
    mem_rt_value   = rt;
    mem_dest       = dest;
    mem_rf_we      = we;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
    chk({tag, "_fwd"}, {31'd0, wb_fwd_valid}, 32'd0);
    chk({tag, "_wen"}, {28'd0, debug_wb_rf_wen}, 32'd0);
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
    chk({tag, "_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_pc"}, debug_wb_pc, 32'd0);
    chk({tag, "_retired"}, inst_retired, 32'd0);
    chk({tag, "_allowin"}, {31'd0, wb_allowin}, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    idle_in();
    tick();
  endtask

  // Byte-lane view of the load rules: build the result one byte at a time.
  function automatic logic [31:0] ref_load(
      input logic [2:0] op, input logic [1:0] n,
      input logic [31:0] w, input logic [31:0] rt,
      input logic [31:0] alu);
    logic [7:0] wb[4];
    logic [7:0] rb[4];
    logic [7:0] ob[4];
    int k;
    int v;
    int base;
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    k = int'(n);
    base = (k >= 2) ? 2 : 0;
    case (op)
      3'd1: begin
        v = int'(wb[k]);
        if (v >= 128) v = v - 256;
        return 32'(v);
      end
      3'd2: return 32'(int'(wb[k]));
      3'd3: begin
        v = int'(wb[base+1]) * 256 + int'(wb[base]);
        if (v >= 32768) v = v - 65536;
        return 32'(v);
      end
      3'd4: return 32'(int'(wb[base+1]) * 256 + int'(wb[base]));
      3'd5: return w;
      3'd6: begin
        for (int i = 0; i < 4; i++) begin
          if (i >= 3 - k) ob[i] = wb[i-(3-k)];
          else ob[i] = rb[i];
        end
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      3'd7: begin
        for (int i = 0; i < 4; i++) begin
          if (i <= 3 - k) ob[i] = wb[i+k];
          else ob[i] = rb[i];
        end
        return {ob[3], ob[2], ob[1], ob[0]};
      end
      default: return alu;
    endcase
  endfunction

  initial begin
    vec_t vecs[14];
    instr_t cur;
    instr_t nx;
    bit occ;
    bit fresh;
    bit mv;
    bit st;
    bit allow;
    bit cmt;
    bit wr;
    logic [31:0] word;
    int unsigned ret;

    vecs[0]  = '{3'd1, 2'd3, 32'h80112233, 32'h0, 32'h0, 32'hFFFFFF80};
    vecs[1]  = '{3'd2, 2'd3, 32'h80112233, 32'h0, 32'h0, 32'h00000080};
    vecs[2]  = '{3'd1, 2'd1, 32'h80112233, 32'h0, 32'h0, 32'h00000022};
    vecs[3]  = '{3'd6, 2'd0, 32'h44332211, 32'hAABBCCDD, 32'h0, 32'h11BBCCDD};
    vecs[4]  = '{3'd6, 2'd3, 32'h44332211, 32'hAABBCCDD, 32'h0, 32'h44332211};
    vecs[5]  = '{3'd6, 2'd1, 32'h44332211, 32'hAABBCCDD, 32'h0, 32'h2211CCDD};
    vecs[6]  = '{3'd7, 2'd1, 32'h44332211, 32'hAABBCCDD, 32'h0, 32'hAA443322};
    vecs[7]  = '{3'd7, 2'd3, 32'h44332211, 32'hAABBCCDD, 32'h0, 32'hAABBCC44};
    vecs[8]  = '{3'd7, 2'd0, 32'h44332211, 32'hAABBCCDD, 32'h0, 32'h44332211};
    vecs[9]  = '{3'd3, 2'd2, 32'h80017FFF, 32'h0, 32'h0, 32'hFFFF8001};
    vecs[10] = '{3'd4, 2'd2, 32'h80017FFF, 32'h0, 32'h0, 32'h00008001};
    vecs[11] = '{3'd3, 2'd0, 32'h80017FFF, 32'h0, 32'h0, 32'h00007FFF};
    vecs[12] = '{3'd5, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D};
    vecs[13] = '{3'd0, 2'd2, 32'h55555555, 32'h0, 32'h13579BDF, 32'h13579BDF};

    idle_in();
    reset = 1'b1;
    #1;
    chk_reset_state("por");
    #11;
    reset = 1'b0;
    tick();

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
      tick();
    end
    chk("idle_retired", inst_retired, 32'd0);

    // vector table: one instruction, commit one cycle later
    for (int i = 0; i < 14; i++) begin
      send(32'h1000 + 32'(4*i), vecs[i].op, vecs[i].lo, vecs[i].alu,
           vecs[i].rt, 5'(i + 1), 1'b1);
      tick();
      idle_in();
      data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d_we", i), {31'd0, rf_we}, 32'd1);
      chk($sformatf("vec%0d_data", i), rf_wdata, vecs[i].exp);
      chk($sformatf("vec%0d_pc", i), debug_wb_pc, 32'h1000 + 32'(4*i));
      tick();
    end

    // stall buffering; a waiting instruction must not be captured
    send(32'h2000, 3'd5, 2'd0, 32'h0, 32'h0, 5'd7, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      send(32'h2004, 3'd0, 2'd0, 32'h99, 32'h0, 5'd9, 1'b1);
      wb_stall = 1'b1;
      data_sram_rdata = (c == 0) ? 32'hDEADBEEF : 32'd0;
      #1;
      chk("stall_allowin", {31'd0, wb_allowin}, 32'd0);
      chk("stall_rf_we", {31'd0, rf_we}, 32'd0);
      chk("stall_fwd", {31'd0, wb_fwd_valid}, 32'd1);
      tick();
    end
    wb_stall = 1'b0;
    data_sram_rdata = 32'd0;
    #1;
    chk("unstall_we", {31'd0, rf_we}, 32'd1);
    chk("unstall_data", rf_wdata, 32'hDEADBEEF);
    chk("unstall_addr", {27'd0, rf_waddr}, 32'd7);
    chk("unstall_allowin", {31'd0, wb_allowin}, 32'd1);
    tick();
    idle_in();
    #1;
    chk("b2b_after_stall_we", {31'd0, rf_we}, 32'd1);
    chk("b2b_after_stall_addr", {27'd0, rf_waddr}, 32'd9);
    chk("b2b_after_stall_data", rf_wdata, 32'h99);
    tick();
    #1;
    chk("single_pulse", {31'd0, rf_we}, 32'd0);
    tick();

    // back-to-back ALU commits from a clean count
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) send(32'h3000 + 32'(4*i), 3'd0, 2'd0, 32'(i + 1),
                      32'h0, 5'(i + 1), 1'b1);
      else idle_in();
      #1;
      if (i > 0) begin
        chk($sformatf("b2b%0d_we", i), {31'd0, rf_we}, 32'd1);
        chk($sformatf("b2b%0d_addr", i), {27'd0, rf_waddr}, 32'(i));
        chk($sformatf("b2b%0d_data", i), rf_wdata, 32'(i));
      end
      tick();
    end
    chk("b2b_retired", inst_retired, 32'd5);

    // dest 0 commits without writing
    send(32'h3100, 3'd0, 2'd0, 32'h77, 32'h0, 5'd0, 1'b1);
    tick();
    idle_in();
    #1;
    chk("dest0_we", {31'd0, rf_we}, 32'd0);
    chk("dest0_fwd", {31'd0, wb_fwd_valid}, 32'd0);
    tick();
    chk("dest0_retired", inst_retired, 32'd6);

    // reset while a stalled load is held
    send(32'h4000, 3'd5, 2'd0, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    idle_in();
    wb_stall = 1'b1;
    data_sram_rdata = 32'h12345678;
    #1;
    chk("mid_fwd_before", {31'd0, wb_fwd_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    reset = 1'b0;
    tick();
    wb_stall = 1'b0;
    #1;
    chk("midrst_no_write", {31'd0, rf_we}, 32'd0);
    send(32'h4100, 3'd0, 2'd0, 32'h44, 32'h0, 5'd4, 1'b1);
    tick();
    idle_in();
    #1;
    chk("midrst_next_we", {31'd0, rf_we}, 32'd1);
    chk("midrst_next_data", rf_wdata, 32'h44);
    tick();
    chk("midrst_retired", inst_retired, 32'd1);

    // randomized run against the reference model
    pulse_reset();
    occ = 0;
    fresh = 0;
    ret = 0;
    word = 32'd0;
    cur = '{32'd0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0};
    for (int cyc = 0; cyc < 2000; cyc++) begin
      nx.pc   = $urandom;
      nx.op   = 3'($urandom_range(0, 7));
      nx.lo   = 2'($urandom_range(0, 3));
      nx.alu  = $urandom;
      nx.rt   = $urandom;
      nx.dest = 5'($urandom_range(0, 31));
      nx.we   = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 2) != 0);
      st = ($urandom_range(0, 3) == 0);
      send(nx.pc, nx.op, nx.lo, nx.alu, nx.rt, nx.dest, nx.we);
      mem_valid = mv;
      wb_stall = st;
      data_sram_rdata = $urandom;
      if (occ && fresh) word = data_sram_rdata;
      #1;
      allow = !occ || !st;
      cmt = occ && !st;
      wr = cur.we && (cur.dest != 5'd0);
      chk("rnd_allowin", {31'd0, wb_allowin}, {31'd0, allow});
      chk("rnd_fwd", {31'd0, wb_fwd_valid}, {31'd0, occ && wr});
      chk("rnd_we", {31'd0, rf_we}, {31'd0, cmt && wr});
      if (cmt && wr) begin
        chk("rnd_addr", {27'd0, debug_wb_rf_wnum}, {27'd0, cur.dest});
        chk("rnd_data", debug_wb_rf_wdata,
            ref_load(cur.op, cur.lo, word, cur.rt, cur.alu));
        chk("rnd_pc", debug_wb_pc, cur.pc);
        chk("rnd_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
      end
      tick();
      if (cmt) ret++;
      fresh = allow && mv;
      if (fresh) cur = nx;
      if (allow) occ = mv;
      if (cyc % 100 == 99) chk("rnd_retired", inst_retired, ret);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
